// File: rtl/wrr_arb_tree.sv
// Weighted round-robin arbiter: NumIn valid/ready sources onto one destination.
// Each source keeps priority for up to its weight in transfers, with lock-in and an optional output slot.
module wrr_arb_tree #(
    parameter int unsigned  NumIn       = 8,
    parameter int unsigned  DataWidth   = 32,
    parameter int unsigned  WeightWidth = 4,
    parameter bit           OutReg      = 1'b1,
    parameter bit           LockIn      = 1'b1,
    localparam int unsigned IdxWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic [NumIn-1:0][WeightWidth-1:0] weight_i,
    input  logic [NumIn-1:0]                  mask_i,
    input  logic [NumIn-1:0]                  req_i,
    output logic [NumIn-1:0]                  gnt_o,
    input  logic [NumIn-1:0][DataWidth-1:0]   data_i,
    output logic                              req_o,
    input  logic                              gnt_i,
    output logic [DataWidth-1:0]              data_o,
    output logic [IdxWidth-1:0]               idx_o
);

    localparam int unsigned         CntWidth = WeightWidth + 1;
    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumIn - 1);

    logic [IdxWidth-1:0]    ptr_q, ptr_d;
    logic [WeightWidth-1:0] cnt_q, cnt_d;
    logic                   lock_q, lock_d;
    logic [IdxWidth-1:0]    lidx_q, lidx_d;

    logic                   clr;
    logic [NumIn-1:0]       elig;
    logic [IdxWidth-1:0]    srch_idx;
    logic                   srch_vld;
    logic [IdxWidth-1:0]    win_idx;
    logic                   win_vld;
    logic                   rdy;
    logic                   xfer;
    logic [CntWidth-1:0]    cnt_inc;
    logic [CntWidth-1:0]    wgt_eff;

    function automatic logic [IdxWidth-1:0] lowest_set(input logic [NumIn-1:0] vec);
        logic [IdxWidth-1:0] idx;
        idx = '0;
        for (int k = int'(NumIn) - 1; k >= 0; k--) begin
            if (vec[k]) idx = IdxWidth'(k);
        end
        return idx;
    endfunction

    assign clr  = rst_i | flush_i;
    assign elig = req_i & ~mask_i;

    // Cyclic search: prefer eligible sources at or above ptr_q, otherwise wrap to the lowest one.
    if (NumIn == 1) begin : g_single
        assign srch_idx = '0;
        assign srch_vld = elig[0];
    end else begin : g_search
        logic [NumIn-1:0] upper;
        always_comb begin
            upper = '0;
            for (int unsigned k = 0; k < NumIn; k++) begin
                upper[k] = elig[k] && (IdxWidth'(k) >= ptr_q);
            end
        end
        assign srch_idx = (|upper) ? lowest_set(upper) : lowest_set(elig);
        assign srch_vld = |elig;
    end

    // A locked decision overrides new requests and the mask until it transfers.
    always_comb begin
        win_idx = srch_idx;
        win_vld = srch_vld;
        if (LockIn && lock_q) begin
            win_idx = lidx_q;
            win_vld = req_i[lidx_q];
        end
        if (clr) win_vld = 1'b0;
    end

    assign xfer = rdy & win_vld;

    always_comb begin
        gnt_o = '0;
        if (xfer) gnt_o[win_idx] = 1'b1;
    end

    // Quota bookkeeping: count back-to-back grants to the owner, move on once the weight is used.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        lidx_d  = lidx_q;
        cnt_inc = (win_idx == ptr_q) ? CntWidth'(cnt_q) + CntWidth'(1) : CntWidth'(1);
        wgt_eff = (weight_i[win_idx] == '0) ? CntWidth'(1) : CntWidth'(weight_i[win_idx]);
        if (clr) begin
            ptr_d  = '0;
            cnt_d  = '0;
            lock_d = 1'b0;
            lidx_d = '0;
        end else if (xfer) begin
            lock_d = 1'b0;
            if (NumIn == 1) begin
                ptr_d = '0;
                cnt_d = '0;
            end else if (cnt_inc >= wgt_eff) begin
                ptr_d = (win_idx == LastIdx) ? '0 : win_idx + IdxWidth'(1);
                cnt_d = '0;
            end else begin
                ptr_d = win_idx;
                cnt_d = cnt_inc[WeightWidth-1:0];
            end
        end else if (LockIn && win_vld) begin
            lock_d = 1'b1;
            lidx_d = win_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
            lidx_q <= lidx_d;
        end
    end

    if (OutReg) begin : g_slot
        logic                 v_q, v_d;
        logic [DataWidth-1:0] d_q, d_d;
        logic [IdxWidth-1:0]  i_q, i_d;

        assign rdy = ~v_q | gnt_i;

        // Load and drain in the same cycle keeps the slot full for back-to-back beats.
        always_comb begin
            v_d = v_q;
            d_d = d_q;
            i_d = i_q;
            if (clr) begin
                v_d = 1'b0;
                d_d = '0;
                i_d = '0;
            end else if (xfer) begin
                v_d = 1'b1;
                d_d = data_i[win_idx];
                i_d = win_idx;
            end else if (gnt_i) begin
                v_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v_q <= 1'b0;
                d_q <= '0;
                i_q <= '0;
            end else begin
                v_q <= v_d;
                d_q <= d_d;
                i_q <= i_d;
            end
        end

        assign req_o  = v_q;
        assign data_o = d_q;
        assign idx_o  = i_q;
    end else begin : g_pass
        assign rdy    = gnt_i;
        assign req_o  = win_vld;
        assign data_o = win_vld ? data_i[win_idx] : '0;
        assign idx_o  = win_vld ? win_idx : '0;
    end

    // A locked source must keep its request up until it is granted.
    a_lock_hold: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
                                  (LockIn && lock_q) |-> req_i[lidx_q]);

endmodule

// File: tb/tb_wrr_arb_tree.sv
// Bench for wrr_arb_tree: instance A (4 sources, output slot) and B (3 sources, pass-through)
// checked every cycle against a behavioural model, plus directed arbitration sequences.
module tb_wrr_arb_tree;

    localparam int unsigned NW = 4;
    localparam int unsigned NB = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned WW = 4;
    localparam int unsigned IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, flush, gnt_in;
    logic [NW-1:0]         mask;
    logic [NW-1:0][WW-1:0] wt;
    logic [NW-1:0]         req_s [2];
    logic [NW-1:0][DW-1:0] dat_s [2];

    logic [NW-1:0] gnt_a;
    logic [NB-1:0] gnt_b;
    logic          rq_a, rq_b;
    logic [DW-1:0] do_a, do_b;
    logic [IW-1:0] ix_a, ix_b;

    wrr_arb_tree #(.NumIn(NW), .DataWidth(DW), .WeightWidth(WW), .OutReg(1'b1), .LockIn(1'b1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .weight_i(wt), .mask_i(mask),
        .req_i(req_s[0]), .gnt_o(gnt_a), .data_i(dat_s[0]), .req_o(rq_a), .gnt_i(gnt_in),
        .data_o(do_a), .idx_o(ix_a));

    wrr_arb_tree #(.NumIn(NB), .DataWidth(DW), .WeightWidth(WW), .OutReg(1'b0), .LockIn(1'b1)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .weight_i(wt[NB-1:0]), .mask_i(mask[NB-1:0]),
        .req_i(req_s[1][NB-1:0]), .gnt_o(gnt_b), .data_i(dat_s[1][NB-1:0]), .req_o(rq_b), .gnt_i(gnt_in),
        .data_o(do_b), .idx_o(ix_b));

    // Planned inputs, applied just after the next rising edge.
    logic                  nx_rst, nx_flush, nx_gnt;
    logic [NW-1:0]         nx_mask;
    logic [NW-1:0][WW-1:0] nx_wt;

    // Sources hold a beat until it is granted; payload = {source, instance, sequence}.
    logic [NW-1:0] pend [2];
    logic [7:0]    seq  [2][NW];

    // Reference state.
    int            m_ptr [2];
    int            m_cnt [2];
    int            m_lock[2];
    int            m_lidx[2];
    bit            m_sv;
    logic [DW-1:0] m_sd;
    int            m_si;

    int dlv_a[$];
    int exp_q[$];
    int acc_a;
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, " beats"}, 32'(dlv_a.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("%s beat%0d", tag, k),
                (k < dlv_a.size()) ? 32'(dlv_a[k]) : 32'hFFFF_FFFF, 32'(exp_q[k]));
        end
    endtask

    task automatic model_step(input int i);
        int            n, w, c, wq;
        bit            wv, rdy, xfer, clr, er;
        logic [NW-1:0] el, eg, ag;
        logic          ar;
        logic [DW-1:0] ad, ed;
        int            ax, ex;
        string         nm;
        nm  = (i == 0) ? "A" : "B";
        n   = (i == 0) ? NW : NB;
        clr = rst || flush;
        el  = req_s[i] & ~mask;
        w   = 0;
        wv  = 1'b0;
        if (m_lock[i] != 0) begin
            w  = m_lidx[i];
            wv = req_s[i][w];
        end else begin
            for (int k = 0; k < n; k++) begin
                int j;
                j = (m_ptr[i] + k) % n;
                if (!wv && el[j]) begin
                    wv = 1'b1;
                    w  = j;
                end
            end
        end
        if (clr) wv = 1'b0;
        rdy  = (i == 0) ? (!m_sv || gnt_in) : gnt_in;
        xfer = rdy && wv;
        eg   = '0;
        if (xfer) eg[w] = 1'b1;

        if (i == 0) begin
            ag = gnt_a;          ar = rq_a; ad = do_a; ax = int'(ix_a);
            er = m_sv;           ed = m_sd; ex = m_si;
        end else begin
            ag = {1'b0, gnt_b};  ar = rq_b; ad = do_b; ax = int'(ix_b);
            er = wv;             ed = dat_s[1][w]; ex = w;
        end
        chk({nm, ".gnt_o"}, 32'(ag), 32'(eg));
        chk({nm, ".req_o"}, 32'(ar), 32'(er));
        if (er) begin
            chk({nm, ".data_o"}, 32'(ad), 32'(ed));
            chk({nm, ".idx_o"}, 32'(ax), 32'(ex));
        end

        if (clr) begin
            m_ptr[i]  = 0;
            m_cnt[i]  = 0;
            m_lock[i] = 0;
            if (i == 0) begin
                m_sv = 1'b0;
                m_sd = '0;
                m_si = 0;
            end
        end else begin
            if (xfer) begin
                c  = (w == m_ptr[i]) ? m_cnt[i] + 1 : 1;
                wq = (wt[w] == '0) ? 1 : int'(wt[w]);
                if (c >= wq) begin
                    m_ptr[i] = (w + 1) % n;
                    m_cnt[i] = 0;
                end else begin
                    m_ptr[i] = w;
                    m_cnt[i] = c;
                end
                m_lock[i]   = 0;
                pend[i][w]  = 1'b0;
                seq[i][w]   = seq[i][w] + 8'd1;
            end else if (wv) begin
                m_lock[i] = 1;
                m_lidx[i] = w;
            end
            if (i == 0) begin
                if (xfer) begin
                    m_sv = 1'b1;
                    m_sd = dat_s[0][w];
                    m_si = w;
                end else if (gnt_in) begin
                    m_sv = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        rst    = nx_rst;
        flush  = nx_flush;
        gnt_in = nx_gnt;
        mask   = nx_mask;
        wt     = nx_wt;
        for (int i = 0; i < 2; i++) begin
            req_s[i] = pend[i];
            for (int k = 0; k < NW; k++) dat_s[i][k] = {4'(k), 4'(i), seq[i][k]};
        end
        @(negedge clk);
        if (rq_a && gnt_in) dlv_a.push_back(int'(ix_a));
        if (gnt_a != '0) acc_a++;
        model_step(0);
        model_step(1);
    endtask

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        nx_wt = {4'(w3), 4'(w2), 4'(w1), 4'(w0)};
    endtask

    task automatic do_clear(input bit use_rst);
        nx_rst   = use_rst;
        nx_flush = !use_rst;
        cycle();
        nx_rst   = 1'b0;
        nx_flush = 1'b0;
        dlv_a.delete();
        acc_a = 0;
    endtask

    task automatic flush_test(input bit use_rst, input string tag);
        pend[0] = '0;
        set_w(3, 1, 1, 1);
        nx_gnt = 1'b1;
        do_clear(1'b0);
        repeat (2) begin
            pend[0] = '1;
            cycle();
        end
        pend[0]  = '1;
        nx_rst   = use_rst;
        nx_flush = !use_rst;
        cycle();
        chk({tag, " gnt during clear"}, 32'(gnt_a), 32'h0);
        nx_rst   = 1'b0;
        nx_flush = 1'b0;
        dlv_a.delete();
        cycle();
        chk({tag, " req_o after clear"}, 32'(rq_a), 32'h0);
        repeat (4) begin
            pend[0] = '1;
            cycle();
        end
        exp_q.delete();
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
        chk_seq({tag, " restart"});
    endtask

    int            wpat[7] = '{0, 0, 0, 1, 2, 2, 3};
    logic [DW-1:0] hold_d;

    initial begin
        rst = 1'b1; flush = 1'b0; gnt_in = 1'b0; mask = '0; wt = '0;
        nx_rst = 1'b1; nx_flush = 1'b0; nx_gnt = 1'b0; nx_mask = '0; nx_wt = '0;
        acc_a = 0; m_sv = 1'b0; m_sd = '0; m_si = 0; hold_d = '0;
        for (int i = 0; i < 2; i++) begin
            req_s[i] = '0; pend[i] = '0; dat_s[i] = '0;
            m_ptr[i] = 0; m_cnt[i] = 0; m_lock[i] = 0; m_lidx[i] = 0;
            for (int k = 0; k < NW; k++) seq[i][k] = 8'd0;
        end

        cycle();
        cycle();
        nx_rst = 1'b0;
        cycle();
        chk("reset req_o", 32'(rq_a), 32'h0);
        chk("reset data_o", 32'(do_a), 32'h0);
        chk("reset idx_o", 32'(ix_a), 32'h0);
        chk("reset gnt_o", 32'(gnt_a), 32'h0);
        chk("reset B req_o", 32'(rq_b), 32'h0);

        // Equal weights: round robin, one beat per cycle after a cycle of latency.
        set_w(1, 1, 1, 1);
        nx_gnt = 1'b1;
        do_clear(1'b1);
        repeat (9) begin
            pend[0] = '1;
            cycle();
        end
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(k % 4);
        chk_seq("equal");

        // Weighted shares {3,1,2,1}.
        pend[0] = '0;
        set_w(3, 1, 2, 1);
        do_clear(1'b0);
        repeat (15) begin
            pend[0] = '1;
            cycle();
        end
        exp_q.delete();
        for (int k = 0; k < 14; k++) exp_q.push_back(wpat[k % 7]);
        chk_seq("weighted");

        // Weight 0 on the last source: every grant wraps the pointer to 0.
        pend[0] = '0;
        set_w(1, 1, 1, 0);
        do_clear(1'b0);
        repeat (6) begin
            pend[0] = 4'b1000;
            cycle();
        end
        exp_q.delete();
        for (int k = 0; k < 5; k++) exp_q.push_back(3);
        chk_seq("weight0");
        pend[0] = '1;
        cycle();
        chk("wrap to source 0", 32'(gnt_a), 32'h1);

        // Lock-in on the pass-through instance.
        pend[0] = '0;
        pend[1] = '0;
        set_w(1, 1, 1, 1);
        nx_gnt = 1'b0;
        do_clear(1'b0);
        pend[1] = 4'b0100;
        cycle();
        chk("lock first idx", 32'(ix_b), 32'h2);
        chk("lock first req", 32'(rq_b), 32'h1);
        pend[1] = pend[1] | 4'b0001;
        nx_mask = 4'b0100;
        repeat (2) cycle();
        chk("lock held idx", 32'(ix_b), 32'h2);
        nx_gnt = 1'b1;
        cycle();
        chk("lock release gnt", 32'(gnt_b), 32'h4);
        cycle();
        chk("after lock gnt", 32'(gnt_b), 32'h1);
        chk("after lock idx", 32'(ix_b), 32'h0);
        nx_mask = '0;

        // Back-pressure on the registered slot.
        pend[0] = '0;
        nx_gnt = 1'b0;
        do_clear(1'b0);
        pend[0] = 4'b1111;
        cycle();
        cycle();
        hold_d = do_a;
        repeat (3) cycle();
        chk("bp accepted", 32'(acc_a), 32'h1);
        chk("bp gnt_o", 32'(gnt_a), 32'h0);
        chk("bp req_o", 32'(rq_a), 32'h1);
        chk("bp data stable", 32'(do_a), 32'(hold_d));
        nx_gnt = 1'b1;
        dlv_a.delete();
        repeat (5) cycle();
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(k);
        chk_seq("bp release");

        flush_test(1'b0, "flush");
        flush_test(1'b1, "reset");

        // Random traffic against the model.
        pend[0] = '0;
        pend[1] = '0;
        do_clear(1'b0);
        for (int t = 0; t < 3000; t++) begin
            nx_gnt   = ($urandom_range(0, 9) < 7);
            nx_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            nx_flush = ($urandom_range(0, 99) == 0);
            nx_rst   = ($urandom_range(0, 399) == 0);
            if (t % 64 == 0) begin
                for (int k = 0; k < NW; k++) nx_wt[k] = 4'($urandom_range(0, 5));
            end
            pend[0] = pend[0] | 4'($urandom);
            pend[1] = pend[1] | (4'($urandom) & 4'b0111);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
